ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The module SHALL have parameters DATA_W, default 32, data width.
REQ-002 The module SHALL have parameters ADDR_W, default 32, address width.
REQ-003 The module SHALL have parameter MAX_HOLD, default 4, the maximum number of consecutive transfers one owner may make while the other master requests.
REQ-004 The module SHALL have these ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req / m1_req  in  1  master request, held high until granted.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  ADDR_W  word address.
- m0_wdata / m1_wdata  in  DATA_W  write data.
- m0_gnt / m1_gnt  out  1  transfer accepted this cycle.
- m0_rvalid / m1_rvalid  out  1  read data valid, one cycle.
- m0_rdata / m1_rdata  out  DATA_W  read data.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM combinational read data.

Function
REQ-005 The FSM SHALL have the states IDLE, OWN0 and OWN1, registered, with reset state IDLE.
REQ-006 In IDLE:
- No gnt SHALL be asserted.
- If exactly one req is high, that master's OWN state SHALL be entered next cycle.
- If both reqs are high, the master other than last_owner SHALL be granted.
- last_owner SHALL reset to 1, so m0 wins the first tie.
REQ-007 In OWNx, mx_gnt SHALL equal mx_req combinationally, and the other gnt SHALL be 0.
REQ-008 A transfer SHALL occur on each rising edge where mx_req and mx_gnt are both high.
REQ-009 While OWNx, ram_addr, ram_wdata and ram_we SHALL be driven from master x.
- ram_we SHALL equal mx_we AND mx_req.
- In IDLE, ram_we SHALL be 0, and ram_addr and ram_wdata SHALL be 0.
REQ-010 A hold counter (width clog2(MAX_HOLD)+1) SHALL behave as follows:
- It SHALL increment on each transfer by the owner.
- It SHALL saturate at MAX_HOLD.
- It SHALL clear to 0 on any ownership change or entry to IDLE.
REQ-011 OWNx transitions, with priority in this order:
- (a) If mx_req is low and the other req is high, go to OWN(other).
- (b) If mx_req is low and the other req is low, go to IDLE.
- (c) If a transfer occurs that brings the counter to MAX_HOLD and the other req is high, go to OWN(other).
- (d) Otherwise stay in OWNx.
REQ-012 last_owner SHALL update to x whenever OWNx is left.
REQ-013 On a read transfer, ram_rdata SHALL be registered into mx_rdata, and mx_rvalid SHALL pulse high in the following cycle only.
REQ-014 Write transfers SHALL NOT assert rvalid.
REQ-015 mx_rdata SHALL hold its last value when rvalid is low.
REQ-016 If the other master never requests, the owner SHALL keep ownership indefinitely, with the counter saturated.
REQ-017 Latency SHALL be one cycle from req rising in IDLE to gnt, and zero idle cycles between back-to-back transfers of one owner.
REQ-018 On a handover, the new owner's gnt SHALL assert the cycle after the last transfer by the previous owner.

Reset
REQ-019 When reset is low, the following SHALL clear asynchronously: state=IDLE, last_owner=1, counter=0, rvalid=0, rdata=0.
REQ-020 All outputs SHALL be 0 during reset, and a read pending its rvalid SHALL be dropped.
REQ-021 Release of reset SHALL take effect on the next rising clk edge.

Structure
REQ-022 The state enum arb_state_t SHALL reside in a shared package ram_arb_pkg.
REQ-023 The package SHALL also hold the MAX_HOLD default, named ARB_MAX_HOLD.
REQ-024 The design SHALL be a single module with no sub-modules, and SHALL sit between the core data port and the RAM in the MCU top.

Verification
REQ-025 Single read: write 0x1234_5678 via m0 to addr 0x10, then m0 reads 0x10 -> m0_gnt 1 cycle after req, m0_rvalid next cycle with m0_rdata=0x1234_5678, m1 outputs 0.
REQ-026 Tie from reset: both req high on the first cycle after reset -> m0 granted first.
- After m0 drops req, m1 is granted the next cycle.
- A later tie from IDLE grants m0, since last_owner=1.
REQ-027 Hold limit: m0 and m1 both request continuously with MAX_HOLD=4 -> exactly 4 m0 transfers, then 4 m1 transfers, alternating with no idle cycle.
REQ-028 Saturation: m0 requests 10 consecutive writes with m1 idle -> 10 gnt cycles, ram_we high for all 10, state stays OWN0.
- m1 rising afterwards causes a switch after the next m0 transfer.
REQ-029 Reset mid-read: reset asserted low in the cycle after an m1 read transfer -> m1_rvalid never asserts, all outputs 0.
- After release, m1_req gets gnt one cycle later.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-master RAM arbiter.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   localparam int unsigned ARB_MAX_HOLD = 4;

endpackage

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port RAM with combinational read.
// An owner keeps the RAM for back-to-back transfers until it drops its request
// or has made MAX_HOLD consecutive transfers while the other master waits.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned MAX_HOLD = ARB_MAX_HOLD
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int unsigned CNT_W = $clog2(MAX_HOLD) + 1;
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

   arb_state_t       state;
   arb_state_t       state_nxt;
   logic             last_owner;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] hold_sat;
   logic             own_xfer;

   // Grants follow the owner's request directly; RAM port is muxed from the owner.
   always_comb begin
      m0_gnt    = (state == OWN0) && m0_req;
      m1_gnt    = (state == OWN1) && m1_req;
      own_xfer  = m0_gnt || m1_gnt;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      case (state)
         OWN0: begin
            ram_we    = m0_we && m0_req;
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
         end
         OWN1: begin
            ram_we    = m1_we && m1_req;
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
         end
         default: ;
      endcase
   end

   // Hold count after a transfer this cycle, saturating at MAX_HOLD.
   always_comb begin
      hold_sat = (hold_cnt == HOLD_MAX) ? HOLD_MAX : hold_cnt + 1'b1;
   end

   // Next ownership: drop-out first, then hold-limit handover (a saturated
   // counter still counts as reaching the limit, so a late requester gets in
   // after the owner's next transfer).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (m0_req && m1_req) state_nxt = last_owner ? OWN0 : OWN1;
            else if (m0_req)      state_nxt = OWN0;
            else if (m1_req)      state_nxt = OWN1;
         end
         OWN0: begin
            if (!m0_req)                              state_nxt = m1_req ? OWN1 : IDLE;
            else if (hold_sat == HOLD_MAX && m1_req) state_nxt = OWN1;
         end
         OWN1: begin
            if (!m1_req)                              state_nxt = m0_req ? OWN0 : IDLE;
            else if (hold_sat == HOLD_MAX && m0_req) state_nxt = OWN0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Ownership state, last owner and hold counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         hold_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state != IDLE && state_nxt != state)
            last_owner <= (state == OWN1);
         if (state == IDLE || state_nxt != state)
            hold_cnt <= '0;
         else if (own_xfer)
            hold_cnt <= hold_sat;
      end
   end

   // Capture read data on read transfers; rvalid is a one-cycle pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         m0_rvalid <= m0_gnt && !m0_we;
         m1_rvalid <= m1_gnt && !m1_we;
         if (m0_gnt && !m0_we) m0_rdata <= ram_rdata;
         if (m1_gnt && !m1_we) m1_rdata <= ram_rdata;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small behavioural RAM.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        ram_we;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;

   logic [31:0] mem [0:255];

   int checks = 0;
   int errors = 0;

   ram_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_HOLD(4)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   assign ram_rdata = mem[ram_addr[7:0]];

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_m0_gnt"},    m0_gnt,    0);
      check({tag, "_m1_gnt"},    m1_gnt,    0);
      check({tag, "_m0_rvalid"}, m0_rvalid, 0);
      check({tag, "_m1_rvalid"}, m1_rvalid, 0);
      check({tag, "_m0_rdata"},  m0_rdata,  0);
      check({tag, "_m1_rdata"},  m1_rdata,  0);
      check({tag, "_ram_we"},    ram_we,    0);
      check({tag, "_ram_addr"},  ram_addr,  0);
      check({tag, "_ram_wdata"}, ram_wdata, 0);
   endtask

   // Hold reset for two cycles; release at #1 after an edge so the next edge is active.
   task automatic do_reset();
      clear_inputs();
      reset = 0;
      step();
      step();
      reset = 1;
   endtask

   initial begin
      reset = 0;
      clear_inputs();
      step();
      check_all_zero("rst");

      // ---- single write then single read by m0 ----
      reset = 1;
      step();
      m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'h1234_5678;
      #1 check("wr_idle_gnt", m0_gnt, 0);
      step();
      check("wr_gnt", m0_gnt, 1);
      check("wr_ram_we", ram_we, 1);
      check("wr_ram_addr", ram_addr, 32'h10);
      check("wr_ram_wdata", ram_wdata, 32'h1234_5678);
      step();
      m0_req = 0;
      #1 check("wr_drop_gnt", m0_gnt, 0);
      check("wr_drop_we", ram_we, 0);
      step();
      m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_wdata = '0;
      #1 check("rd_idle_gnt", m0_gnt, 0);
      step();
      check("rd_gnt", m0_gnt, 1);
      check("rd_ram_we", ram_we, 0);
      step();
      m0_req = 0;
      #1 check("rd_rvalid", m0_rvalid, 1);
      check("rd_rdata", m0_rdata, 32'h1234_5678);
      check("rd_m1_rvalid", m1_rvalid, 0);
      check("rd_m1_rdata", m1_rdata, 0);
      check("rd_m1_gnt", m1_gnt, 0);
      step();
      check("rd_rvalid_pulse", m0_rvalid, 0);
      check("rd_rdata_hold", m0_rdata, 32'h1234_5678);

      // ---- tie straight out of reset ----
      do_reset();
      m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'hAAAA_0000;
      m1_req = 1; m1_we = 1; m1_addr = 32'h21; m1_wdata = 32'hBBBB_0000;
      #1 check("tie_idle_m0", m0_gnt, 0);
      step();
      check("tie_m0_gnt", m0_gnt, 1);
      check("tie_m1_gnt", m1_gnt, 0);
      check("tie_ram_addr", ram_addr, 32'h20);
      step();
      m0_req = 0;
      #1 check("tie_m0_drop", m0_gnt, 0);
      check("tie_m1_wait", m1_gnt, 0);
      step();
      check("tie_m1_gnt", m1_gnt, 1);
      check("tie_m1_addr", ram_addr, 32'h21);
      check("tie_m1_wdata", ram_wdata, 32'hBBBB_0000);
      step();
      m1_req = 0;
      step();
      m0_req = 1; m1_req = 1;
      #1 check("tie2_idle_m0", m0_gnt, 0);
      check("tie2_idle_m1", m1_gnt, 0);
      step();
      check("tie2_m0_gnt", m0_gnt, 1);
      check("tie2_m1_gnt", m1_gnt, 0);
      m0_req = 0; m1_req = 0;
      step();

      // ---- hold limit alternation with both masters requesting ----
      do_reset();
      m0_req = 1; m0_we = 1; m0_addr = 32'h30; m0_wdata = 32'h30;
      m1_req = 1; m1_we = 1; m1_addr = 32'h31; m1_wdata = 32'h31;
      for (int i = 1; i <= 12; i++) begin
         logic exp0;
         step();
         exp0 = (i <= 4) || (i >= 9);
         check($sformatf("hold_m0_%0d", i), m0_gnt, exp0);
         check($sformatf("hold_m1_%0d", i), m1_gnt, !exp0);
         check($sformatf("hold_addr_%0d", i), ram_addr, exp0 ? 32'h30 : 32'h31);
      end
      clear_inputs();
      step();
      step();

      // ---- saturation: m0 alone for 10 writes, then m1 joins ----
      do_reset();
      m0_req = 1; m0_we = 1; m0_addr = 32'h50;
      for (int i = 1; i <= 10; i++) begin
         step();
         m0_wdata = 32'h100 + 32'(i);
         #1 check($sformatf("sat_gnt_%0d", i), m0_gnt, 1);
         check($sformatf("sat_we_%0d", i), ram_we, 1);
         check($sformatf("sat_wdata_%0d", i), ram_wdata, 32'h100 + 32'(i));
         check($sformatf("sat_m1_%0d", i), m1_gnt, 0);
      end
      step();
      m1_req = 1; m1_we = 1; m1_addr = 32'h51; m1_wdata = 32'h51;
      #1 check("sat_last_m0", m0_gnt, 1);
      check("sat_last_m1", m1_gnt, 0);
      step();
      check("sat_switch_m1", m1_gnt, 1);
      check("sat_switch_m0", m0_gnt, 0);
      check("sat_mem", mem[8'h50], 32'h10A);
      clear_inputs();
      step();
      step();

      // ---- reset in the cycle after an m1 read ----
      do_reset();
      m1_req = 1; m1_we = 0; m1_addr = 32'h10;
      step();
      check("rstrd_gnt", m1_gnt, 1);
      step();
      reset = 0;
      #1 check_all_zero("rstrd");
      step();
      check_all_zero("rstrd_hold");
      reset = 1;
      #1 check("rstrd_rel_gnt0", m1_gnt, 0);
      step();
      check("rstrd_rel_gnt1", m1_gnt, 1);
      check("rstrd_rel_rvalid", m1_rvalid, 0);
      m1_req = 0;
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
